zoom_coord_gen: RTL and testbench
=================================

Name: zoom_coord_gen

Overview:
- Downstream consumer of the latched zoom factor (12-bit percent code: 100 = 1.00x, nominal range 110..400).
- Once per frame it converts the factor into a Q16 source-pixel step using a sequential divider.
- It then computes a centred crop origin and emits a fractional source coordinate (x, y) for each raster-order output-pixel request.
- Its outputs feed the line-buffer read/interpolation stage of the digital-zoom path.

Parameters:
- H_ACTIVE, 640, output/source active width in pixels
- V_ACTIVE, 512, output/source active height in lines
- FRAC_BITS, 16, fractional bits of step and accumulators
- COORD_W, 11, integer bits of source coordinates
- OFRAC_W, 8, fractional bits presented on outputs (MSBs of fraction)

Ports:
- i_Sys_clk  in  1  system clock
- i_Rst  in  1  asynchronous, active-high reset
- i_Cmd_scaler  in  12  zoom factor in percent; sampled only on i_Frame_start
- i_Frame_start  in  1  single-cycle pulse, start of frame
- i_Pix_req  in  1  request next output pixel coordinate (raster order)
- o_Ready  out  1  coordinates can be requested
- o_Coord_valid  out  1  o_Src_* valid, one cycle after accepted request
- o_Src_x  out  COORD_W  integer source x
- o_Src_y  out  COORD_W  integer source y
- o_Frac_x  out  OFRAC_W  fractional source x
- o_Frac_y  out  OFRAC_W  fractional source y
- o_Line_end  out  1  qualifies the last pixel of a line (with o_Coord_valid)
- o_Frame_end  out  1  qualifies the last pixel of the frame
- o_Req_drop  out  1  pulse: i_Pix_req arrived while o_Ready low

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, step = 65536, origins = 0.
- FSM states and transitions:
  - IDLE: wait for i_Frame_start.
  - DIV: 23 cycles.
  - ORG: 1 cycle.
  - RUN: accept requests; returns to IDLE after the frame-end pixel.
- i_Frame_start in any state aborts current work and enters DIV. Frame_start at cycle 0 gives DIV on cycles 1..23, ORG on cycle 24, and o_Ready=1 from cycle 25.
- Scale clamp at sample time: S = max(100, min(400, i_Cmd_scaler)). Mid-frame changes of i_Cmd_scaler are ignored.
- Step: step = floor((100<<16) / S), 17-bit, computed by a restoring divider. Dividend 6553600 is 23 bits, giving 23 iterations with quotient in range 16384..65536.
- Origin (computed in ORG, registered):
  - x0 = H_ACTIVE*(65536-step) >> 1
  - y0 = V_ACTIVE*(65536-step) >> 1
  - Both are Q(COORD_W).16, truncated.
- RUN:
  - Each i_Pix_req drives o_Coord_valid the next cycle with o_Src_x = acc_x[int], o_Frac_x = acc_x[15:8], and likewise for y.
  - acc_x starts at x0 and advances by step per request.
  - After H_ACTIVE requests, acc_x reloads x0, acc_y advances by step, and o_Line_end is asserted with the last pixel.
  - After V_ACTIVE lines, o_Frame_end and o_Line_end are asserted with the final pixel, o_Ready drops in the same cycle as that output, and the FSM returns to IDLE.
- Request timing: back-to-back requests are accepted every cycle; throughput is 1 coordinate per clock.
- i_Pix_req when o_Ready=0 is ignored and o_Req_drop pulses 1 cycle later. If i_Frame_start and i_Pix_req coincide, frame_start wins, the request is dropped, and o_Req_drop pulses.
- Accumulators are COORD_W+FRAC_BITS = 27 bits and cannot overflow for legal S (max source coordinate < H_ACTIVE).
- Asynchronous reset mid-operation returns to the reset state immediately; no partial-frame outputs follow.

Decomposition:
- Package zoom_pkg:
  - SCALE_MIN=100, SCALE_MAX=400
  - FRAC_BITS=16
  - DIV_DIVIDEND=6553600
  - DIV_ITER=23
  - FSM state encoding (IDLE/DIV/ORG/RUN)
- Sub-module zoom_step_div: sequential restoring divider.
  - Interface: start, 23-bit dividend, 12-bit divisor, 17-bit quotient, done pulse.
  - A new start re-initialises it.
- The top level holds the clamp, origin multipliers, FSM and accumulators.

Test Plan:
- S=200, frame_start, then 640x512 requests:
  - o_Ready rises 25 cycles after frame_start.
  - First coordinate is x=160.0, y=128.0 (frac 0).
  - Second coordinate is x=160, frac 128.
  - Pixel 639 is x=479, frac 128, with o_Line_end.
  - Final pixel is y=383, frac 128, with o_Frame_end, then o_Ready=0.
- S=100: step 65536, origin 0; coordinates equal the output raster exactly (0..639, 0..511), fractions 0.
- S=110: step 59578; first x=29, frac_x=23 (x0=1906560); S=400: step 16384, first x=240, y=192.
- Clamp: i_Cmd_scaler=50 behaves as S=100. i_Cmd_scaler=4095 behaves as S=400. Changing i_Cmd_scaler mid-RUN does not alter coordinates.
- Handshake edges:
  - Request during DIV gives o_Req_drop and no o_Coord_valid.
  - Frame_start coinciding with a request gives a drop plus a restart.
  - Frame_start mid-RUN with new S restarts at new origin after 25 cycles.
- Assert i_Rst during RUN, then release: all outputs 0, o_Ready=0 until the next frame_start plus 25 cycles.

Source files
------------

// File: rtl/zoom_pkg.sv
// Shared constants and FSM encoding for the zoom coordinate generator.
package zoom_pkg;
  localparam int SCALE_W      = 12;
  localparam int SCALE_MIN    = 100;
  localparam int SCALE_MAX    = 400;
  localparam int FRAC_BITS    = 16;
  localparam int DIV_DIVIDEND = 6553600;
  localparam int DIV_ITER     = 23;
  localparam int DIVIDEND_W   = 23;
  localparam int QUOT_W       = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_ORG  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;
endpackage

// File: rtl/zoom_step_div.sv
// Restoring divider, one quotient bit per clock; the start cycle already
// performs the first iteration so the result is ready DIV_ITER cycles later.
module zoom_step_div
  import zoom_pkg::*;
(
  input  logic                  i_Sys_clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [DIVIDEND_W-1:0] i_Dividend,
  input  logic [SCALE_W-1:0]    i_Divisor,
  output logic [QUOT_W-1:0]     o_Quotient,
  output logic                  o_Done
);
  localparam int CNT_W = $clog2(DIV_ITER + 1);

  typedef struct packed {
    logic [SCALE_W-1:0]    rem;
    logic [DIVIDEND_W-1:0] qd;
  } div_st_t;

  function automatic div_st_t div_iter(input div_st_t s, input logic [SCALE_W-1:0] d);
    logic [SCALE_W:0] trial;
    div_st_t          r;
    trial = {s.rem, s.qd[DIVIDEND_W-1]};
    if (trial >= {1'b0, d}) begin
      r.rem = SCALE_W'(trial - {1'b0, d});
      r.qd  = {s.qd[DIVIDEND_W-2:0], 1'b1};
    end else begin
      r.rem = trial[SCALE_W-1:0];
      r.qd  = {s.qd[DIVIDEND_W-2:0], 1'b0};
    end
    return r;
  endfunction

  div_st_t            init_st;
  div_st_t            st_p0;
  logic [SCALE_W-1:0] divisor_r;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  assign init_st    = '{rem: '0, qd: i_Dividend};
  assign o_Quotient = st_p0.qd[QUOT_W-1:0];

  always_ff @(posedge i_Sys_clk) begin
    if (i_Start) begin
      st_p0     <= div_iter(init_st, i_Divisor);
      divisor_r <= i_Divisor;
    end else if (busy) begin
      st_p0 <= div_iter(st_p0, divisor_r);
    end
  end

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      o_Done <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      if (i_Start) begin
        busy <= 1'b1;
        cnt  <= CNT_W'(1);
      end else if (busy) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DIV_ITER - 1)) begin
          busy   <= 1'b0;
          o_Done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/zoom_coord_gen.sv
// Per-frame zoom step/origin computation and raster-order fractional
// source-coordinate generation for the line-buffer interpolation stage.
module zoom_coord_gen
  import zoom_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 512,
  parameter int FRAC_BITS = zoom_pkg::FRAC_BITS,
  parameter int COORD_W   = 11,
  parameter int OFRAC_W   = 8
) (
  input  logic               i_Sys_clk,
  input  logic               i_Rst,
  input  logic [SCALE_W-1:0] i_Cmd_scaler,
  input  logic               i_Frame_start,
  input  logic               i_Pix_req,
  output logic               o_Ready,
  output logic               o_Coord_valid,
  output logic [COORD_W-1:0] o_Src_x,
  output logic [COORD_W-1:0] o_Src_y,
  output logic [OFRAC_W-1:0] o_Frac_x,
  output logic [OFRAC_W-1:0] o_Frac_y,
  output logic               o_Line_end,
  output logic               o_Frame_end,
  output logic               o_Req_drop
);
  localparam int ACC_W  = COORD_W + FRAC_BITS;
  localparam int PROD_W = ACC_W + 1;
  localparam int PIX_W  = $clog2(H_ACTIVE);
  localparam int LINE_W = $clog2(V_ACTIVE);
  localparam logic [QUOT_W-1:0] STEP_ONE = QUOT_W'(1 << FRAC_BITS);

  function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] s);
    if (s < SCALE_W'(SCALE_MIN)) return SCALE_W'(SCALE_MIN);
    if (s > SCALE_W'(SCALE_MAX)) return SCALE_W'(SCALE_MAX);
    return s;
  endfunction

  // Half of the source span left uncovered by the zoomed window, truncated.
  function automatic logic [ACC_W-1:0] half_span(input int unsigned n,
                                                 input logic [QUOT_W-1:0] step);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(n) * PROD_W'(STEP_ONE - step);
    return prod[PROD_W-1:1];
  endfunction

  state_e              state, state_nxt;
  logic [SCALE_W-1:0]  scale_c;
  logic [QUOT_W-1:0]   div_q;
  logic                div_done;
  logic [QUOT_W-1:0]   step_r;
  logic [ACC_W-1:0]    x0_c, y0_c, x0_r, y0_r;
  logic [ACC_W-1:0]    acc_x_p0, acc_y_p0;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic                vld_p0, last_pix, last_line;

  assign scale_c   = clamp_scale(i_Cmd_scaler);
  assign x0_c      = half_span(H_ACTIVE, step_r);
  assign y0_c      = half_span(V_ACTIVE, step_r);
  assign last_pix  = (pix_cnt == PIX_W'(H_ACTIVE - 1));
  assign last_line = (line_cnt == LINE_W'(V_ACTIVE - 1));

  zoom_step_div u_div (
    .i_Sys_clk  (i_Sys_clk),
    .i_Rst      (i_Rst),
    .i_Start    (i_Frame_start),
    .i_Dividend (DIVIDEND_W'(DIV_DIVIDEND)),
    .i_Divisor  (scale_c),
    .o_Quotient (div_q),
    .o_Done     (div_done)
  );

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_Frame_start) begin
      state_nxt = ST_DIV;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_DIV:  if (div_done) state_nxt = ST_ORG;
        ST_ORG:  state_nxt = ST_RUN;
        ST_RUN:  if (vld_p0 && last_pix && last_line) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A coincident frame start wins over the request.
  always_comb begin
    o_Ready = (state == ST_RUN);
    vld_p0  = o_Ready && i_Pix_req && !i_Frame_start;
  end

  // Stage p0: step/origin registers and raster accumulators.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      step_r   <= STEP_ONE;
      x0_r     <= '0;
      y0_r     <= '0;
      acc_x_p0 <= '0;
      acc_y_p0 <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (div_done) step_r <= div_q;
      if (state == ST_ORG) begin
        x0_r     <= x0_c;
        y0_r     <= y0_c;
        acc_x_p0 <= x0_c;
        acc_y_p0 <= y0_c;
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (vld_p0) begin
        if (last_pix) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + LINE_W'(1);
          acc_x_p0 <= x0_r;
          acc_y_p0 <= acc_y_p0 + ACC_W'(step_r);
        end else begin
          pix_cnt  <= pix_cnt + PIX_W'(1);
          acc_x_p0 <= acc_x_p0 + ACC_W'(step_r);
        end
      end
    end
  end

  // Stage p1: registered coordinate outputs.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Coord_valid <= 1'b0;
      o_Line_end    <= 1'b0;
      o_Frame_end   <= 1'b0;
      o_Req_drop    <= 1'b0;
      o_Src_x       <= '0;
      o_Src_y       <= '0;
      o_Frac_x      <= '0;
      o_Frac_y      <= '0;
    end else begin
      o_Coord_valid <= vld_p0;
      o_Line_end    <= vld_p0 && last_pix;
      o_Frame_end   <= vld_p0 && last_pix && last_line;
      o_Req_drop    <= i_Pix_req && !vld_p0;
      if (vld_p0) begin
        o_Src_x  <= acc_x_p0[ACC_W-1 -: COORD_W];
        o_Src_y  <= acc_y_p0[ACC_W-1 -: COORD_W];
        o_Frac_x <= acc_x_p0[FRAC_BITS-1 -: OFRAC_W];
        o_Frac_y <= acc_y_p0[FRAC_BITS-1 -: OFRAC_W];
      end
    end
  end
endmodule

// File: tb/tb_zoom_coord_gen.sv
// Directed bench for zoom_coord_gen, built with a short frame height to keep full frames brief.
module tb_zoom_coord_gen;
  localparam int H = 640;
  localparam int V = 16;

  logic        clk = 1'b0;
  logic        rst, fs, req;
  logic [11:0] cmd;
  logic        rdy, vld, lend, fend, drop;
  logic [10:0] sx, sy;
  logic [7:0]  fx, fy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zoom_coord_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_Sys_clk     (clk),
    .i_Rst         (rst),
    .i_Cmd_scaler  (cmd),
    .i_Frame_start (fs),
    .i_Pix_req     (req),
    .o_Ready       (rdy),
    .o_Coord_valid (vld),
    .o_Src_x       (sx),
    .o_Src_y       (sy),
    .o_Frac_x      (fx),
    .o_Frac_y      (fy),
    .o_Line_end    (lend),
    .o_Frame_end   (fend),
    .o_Req_drop    (drop)
  );

  typedef struct {
    logic [11:0] cmd;
    int x0, fx0, y0, fy0, x1, fx1;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint all_outs();
    return longint'({rdy, vld, lend, fend, drop, sx, fx, sy, fy});
  endfunction

  task automatic wait_ready(inout int lat);
    while (!rdy && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic start_frame(input logic [11:0] c, output int lat);
    cmd = c;
    fs  = 1'b1;
    tick();
    fs  = 1'b0;
    lat = 0;
    wait_ready(lat);
  endtask

  // Full frame with continuous requests, checked against the closed-form raster model.
  task automatic run_frame(input int s, input string tag);
    longint      step, x0, y0, ax, ay;
    int          col, row;
    logic [41:0] e, a;
    step = 6553600 / s;
    x0   = (longint'(H) * (65536 - step)) >>> 1;
    y0   = (longint'(V) * (65536 - step)) >>> 1;
    req  = 1'b1;
    for (int i = 0; i < H * V; i++) begin
      tick();
      if (i == H * V - 1) req = 1'b0;
      if (i == 100) cmd = 12'd4095;
      col = i % H;
      row = i / H;
      ax  = x0 + longint'(col) * step;
      ay  = y0 + longint'(row) * step;
      e = {1'b1, 1'(col == H - 1), 1'(i == H * V - 1), 1'(i != H * V - 1),
           11'(ax >>> 16), 8'(ax >>> 8), 11'(ay >>> 16), 8'(ay >>> 8)};
      a = {vld, lend, fend, rdy, sx, fx, sy, fy};
      checks++;
      if (a != e) begin
        errors++;
        $display("FAIL %s pix %0d actual v%0d le%0d fe%0d r%0d x%0d.%0d y%0d.%0d required v%0d le%0d fe%0d r%0d x%0d.%0d y%0d.%0d",
                 tag, i, a[41], a[40], a[39], a[38], a[37:27], a[26:19], a[18:8], a[7:0],
                 e[41], e[40], e[39], e[38], e[37:27], e[26:19], e[18:8], e[7:0]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;

    tbl[0] = '{12'd200,  160, 0,   4, 0,   160, 128};
    tbl[1] = '{12'd100,    0, 0,   0, 0,     1,   0};
    tbl[2] = '{12'd110,   29, 23,  0, 186,  30,   0};
    tbl[3] = '{12'd400,  240, 0,   6, 0,   240,  64};
    tbl[4] = '{12'd50,     0, 0,   0, 0,     1,   0};
    tbl[5] = '{12'd4095, 240, 0,   6, 0,   240,  64};

    rst = 1'b1; fs = 1'b0; req = 1'b0; cmd = 12'd0;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    tick();
    chk("post_reset_outs", all_outs(), 0);

    // Each entry after the first restarts a frame that is still in RUN.
    for (int k = 0; k < 6; k++) begin
      start_frame(tbl[k].cmd, lat);
      chk($sformatf("latency_s%0d", tbl[k].cmd), lat, 24);
      req = 1'b1;
      tick();
      chk($sformatf("pix0_s%0d", tbl[k].cmd), {vld, sx, fx, sy, fy},
          {1'b1, 11'(tbl[k].x0), 8'(tbl[k].fx0), 11'(tbl[k].y0), 8'(tbl[k].fy0)});
      tick();
      req = 1'b0;
      chk($sformatf("pix1_s%0d", tbl[k].cmd), {vld, sx, fx, sy, fy},
          {1'b1, 11'(tbl[k].x1), 8'(tbl[k].fx1), 11'(tbl[k].y0), 8'(tbl[k].fy0)});
    end

    cmd = 12'd200; fs = 1'b1; req = 1'b1;
    tick();
    fs = 1'b0; req = 1'b0;
    chk("coincide_drop_vld_rdy", {drop, vld, rdy}, 3'b100);
    lat = 0;
    wait_ready(lat);
    chk("coincide_latency", lat, 24);

    run_frame(200, "frame_s200");

    req = 1'b1;
    tick();
    req = 1'b0;
    chk("after_end_drop_vld", {drop, vld, rdy}, 3'b100);

    cmd = 12'd100; fs = 1'b1;
    tick();
    fs = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("div_req_drop_vld", {drop, vld, rdy}, 3'b100);
    lat = 1;
    wait_ready(lat);
    chk("div_req_latency", lat, 24);

    run_frame(100, "frame_s100");

    start_frame(12'd200, lat);
    chk("pre_rst_latency", lat, 24);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("pre_rst_x", {vld, sx}, {1'b1, 11'd160});
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", all_outs(), 0);
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (all_outs() != 0) bad++;
    end
    chk("idle_after_rst", bad, 0);
    start_frame(12'd4095, lat);
    chk("post_rst_latency", lat, 24);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("post_rst_pix0", {vld, sx, fx, sy, fy}, {1'b1, 11'd240, 8'd0, 11'd6, 8'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
